// File: rtl/mcpu_pkg.sv
// Shared encodings for the second-generation MCPU control FSM: states,
// instruction fields and the datapath mux select codes.
package mcpu_pkg;

   typedef enum logic [4:0] {
      S_IF   = 5'd0,
      S_ID   = 5'd1,
      S_MA   = 5'd2,
      S_MR   = 5'd3,
      S_MWB  = 5'd4,
      S_MW   = 5'd5,
      S_RX   = 5'd6,
      S_RWB  = 5'd7,
      S_BEQ  = 5'd8,
      S_BNE  = 5'd9,
      S_J    = 5'd10,
      S_JAL  = 5'd11,
      S_IX   = 5'd12,
      S_IWB  = 5'd13,
      S_JR   = 5'd14,
      S_EXC  = 5'd15,
      S_ERET = 5'd16
   } state_e;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_LUI   = 6'b001111;
   localparam logic [5:0] OP_COP0  = 6'b010000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   localparam logic [5:0] FN_JR    = 6'b001000;
   localparam logic [5:0] FN_ERET  = 6'b011000;

   localparam logic [2:0] PCSRC_ALU  = 3'd0;
   localparam logic [2:0] PCSRC_OUT  = 3'd1;
   localparam logic [2:0] PCSRC_JMP  = 3'd2;
   localparam logic [2:0] PCSRC_VEC  = 3'd3;
   localparam logic [2:0] PCSRC_EPC  = 3'd4;
   localparam logic [2:0] PCSRC_RS   = 3'd5;

   localparam logic [1:0] REGDST_RT  = 2'd0;
   localparam logic [1:0] REGDST_RD  = 2'd1;
   localparam logic [1:0] REGDST_R31 = 2'd2;

   localparam logic [1:0] M2R_ALU    = 2'd0;
   localparam logic [1:0] M2R_MDR    = 2'd1;
   localparam logic [1:0] M2R_PC     = 2'd2;

   localparam logic [1:0] SRCB_B     = 2'd0;
   localparam logic [1:0] SRCB_4     = 2'd1;
   localparam logic [1:0] SRCB_IMM   = 2'd2;
   localparam logic [1:0] SRCB_IMMSH = 2'd3;

   localparam logic [1:0] ALUOP_ADD  = 2'd0;
   localparam logic [1:0] ALUOP_SUB  = 2'd1;
   localparam logic [1:0] ALUOP_FN   = 2'd2;
   localparam logic [1:0] ALUOP_OPC  = 2'd3;

   localparam logic [1:0] CAUSE_NONE = 2'd0;
   localparam logic [1:0] CAUSE_INT  = 2'd1;
   localparam logic [1:0] CAUSE_ILL  = 2'd2;
   localparam logic [1:0] CAUSE_BUS  = 2'd3;

   localparam logic [31:0] INT_VECTOR_DEF = 32'h0000_0004;

endpackage

// File: rtl/mcpu_ctrl_decode.sv
// Instruction dispatch for the ID state: maps opcode/funct to the first
// execute state and flags anything the core does not implement.
module mcpu_ctrl_decode
   import mcpu_pkg::*;
(
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   output state_e     dispatch_o,
   output logic       illegal_o
);

   always_comb begin
      dispatch_o = S_EXC;
      illegal_o  = 1'b0;
      case (opcode)
         OP_LW, OP_SW:  dispatch_o = S_MA;
         OP_RTYPE:      dispatch_o = (funct == FN_JR) ? S_JR : S_RX;
         OP_BEQ:        dispatch_o = S_BEQ;
         OP_BNE:        dispatch_o = S_BNE;
         OP_J:          dispatch_o = S_J;
         OP_JAL:        dispatch_o = S_JAL;
         OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI, OP_LUI: dispatch_o = S_IX;
         OP_COP0: begin
            if (funct == FN_ERET) dispatch_o = S_ERET;
            else                  illegal_o  = 1'b1;
         end
         default:       illegal_o  = 1'b1;
      endcase
   end

endmodule

// File: rtl/mcpu_ctrl_v2.sv
// Multi-cycle MIPS control FSM with memory wait states, EPC/ERET interrupts
// and illegal-opcode trap. Optional bus timeout: MCTRL_BUS_TIMEOUT_EN.
module mcpu_ctrl_v2
   import mcpu_pkg::*;
#(
   parameter int          STATE_W     = 5,
   parameter logic [31:0] INT_VECTOR  = INT_VECTOR_DEF,
   parameter logic        IE_RST      = 1'b0,
   parameter int          BUS_TIMEOUT = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [5:0]         opcode,
   input  logic [5:0]         funct,
   input  logic               Zero,
   input  logic               MIO_ready,
   input  logic               INT,
   output logic               MemRead,
   output logic               MemWrite,
   output logic               IorD,
   output logic               IRWrite,
   output logic               RegWrite,
   output logic               ALUSrcA,
   output logic               ExtSigned,
   output logic               PCWrite,
   output logic               EPCWrite,
   output logic [1:0]         RegDst,
   output logic [1:0]         MemtoReg,
   output logic [1:0]         ALUSrcB,
   output logic [1:0]         ALUOp,
   output logic [2:0]         PCSrc,
   output logic [1:0]         cause,
   output logic               IE,
   output logic [STATE_W-1:0] state,
   output logic [31:0]        int_vector
);

   state_e     state_q, state_d;
   logic [1:0] cause_q, cause_d;
   logic       ie_q, ie_d;
   state_e     dispatch;
   logic       illegal;
   logic       done;
   logic       timeout;

   mcpu_ctrl_decode u_decode (
      .opcode     (opcode),
      .funct      (funct),
      .dispatch_o (dispatch),
      .illegal_o  (illegal)
   );

`ifdef MCTRL_BUS_TIMEOUT_EN
   localparam int TW = $clog2(BUS_TIMEOUT + 1);
   logic [TW-1:0] wait_cnt_q, wait_cnt_d;
   logic          waiting;

   assign waiting = ((state_q == S_IF) || (state_q == S_MR) || (state_q == S_MW)) && !MIO_ready;
   assign timeout = waiting && (wait_cnt_q == TW'(BUS_TIMEOUT - 1));

   // Any cycle that is not a continued wait in the same state restarts the count.
   always_comb begin
      wait_cnt_d = '0;
      if (waiting && !timeout) wait_cnt_d = wait_cnt_q + 1'b1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) wait_cnt_q <= '0;
      else        wait_cnt_q <= wait_cnt_d;
   end
`else
   logic [31:0] unused_bus_timeout;
   assign unused_bus_timeout = 32'(BUS_TIMEOUT);
   assign timeout = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IF;
         cause_q <= CAUSE_NONE;
         ie_q    <= IE_RST;
      end else begin
         state_q <= state_d;
         cause_q <= cause_d;
         ie_q    <= ie_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cause_d   = cause_q;
      ie_d      = ie_q;
      done      = 1'b0;
      MemRead   = 1'b0;
      MemWrite  = 1'b0;
      IorD      = 1'b0;
      IRWrite   = 1'b0;
      RegWrite  = 1'b0;
      ALUSrcA   = 1'b0;
      ExtSigned = 1'b0;
      PCWrite   = 1'b0;
      EPCWrite  = 1'b0;
      RegDst    = REGDST_RT;
      MemtoReg  = M2R_ALU;
      ALUSrcB   = SRCB_B;
      ALUOp     = ALUOP_ADD;
      PCSrc     = PCSRC_ALU;
      case (state_q)
         S_IF: begin
            MemRead = 1'b1;
            ALUSrcB = SRCB_4;
            IRWrite = MIO_ready;
            PCWrite = MIO_ready;
            if (MIO_ready) state_d = S_ID;
         end
         S_ID: begin
            ALUSrcB = SRCB_IMMSH;
            state_d = dispatch;
            if (illegal) cause_d = CAUSE_ILL;
         end
         S_MA: begin
            ALUSrcA   = 1'b1;
            ALUSrcB   = SRCB_IMM;
            ExtSigned = 1'b1;
            state_d   = (opcode == OP_SW) ? S_MW : S_MR;
         end
         S_MR: begin
            IorD    = 1'b1;
            MemRead = 1'b1;
            if (MIO_ready) state_d = S_MWB;
         end
         S_MW: begin
            IorD     = 1'b1;
            MemWrite = 1'b1;
            done     = MIO_ready;
         end
         S_MWB: begin
            RegWrite = 1'b1;
            MemtoReg = M2R_MDR;
            done     = 1'b1;
         end
         S_RX: begin
            ALUSrcA = 1'b1;
            ALUOp   = ALUOP_FN;
            state_d = S_RWB;
         end
         S_RWB: begin
            ALUSrcA  = 1'b1;
            ALUOp    = ALUOP_FN;
            RegDst   = REGDST_RD;
            RegWrite = 1'b1;
            done     = 1'b1;
         end
         S_IX, S_IWB: begin
            ALUSrcA   = 1'b1;
            ALUSrcB   = SRCB_IMM;
            ALUOp     = ALUOP_OPC;
            ExtSigned = !((opcode == OP_ANDI) || (opcode == OP_ORI));
            if (state_q == S_IX) begin
               state_d = S_IWB;
            end else begin
               RegWrite = 1'b1;
               done     = 1'b1;
            end
         end
         S_BEQ, S_BNE: begin
            ALUSrcA = 1'b1;
            ALUOp   = ALUOP_SUB;
            PCSrc   = PCSRC_OUT;
            PCWrite = (state_q == S_BEQ) ? Zero : !Zero;
            done    = 1'b1;
         end
         S_J: begin
            PCSrc   = PCSRC_JMP;
            PCWrite = 1'b1;
            done    = 1'b1;
         end
         // Link register is written with the PC value from before this cycle's update.
         S_JAL: begin
            RegDst   = REGDST_R31;
            MemtoReg = M2R_PC;
            RegWrite = 1'b1;
            PCSrc    = PCSRC_JMP;
            PCWrite  = 1'b1;
            done     = 1'b1;
         end
         S_JR: begin
            PCSrc   = PCSRC_RS;
            PCWrite = 1'b1;
            done    = 1'b1;
         end
         S_EXC: begin
            EPCWrite = 1'b1;
            PCSrc    = PCSRC_VEC;
            PCWrite  = 1'b1;
            ie_d     = 1'b0;
            state_d  = S_IF;
         end
         S_ERET: begin
            PCSrc   = PCSRC_EPC;
            PCWrite = 1'b1;
            ie_d    = 1'b1;
            state_d = S_IF;
         end
         default: state_d = S_IF;
      endcase

      // Interrupts are only taken on an instruction boundary.
      if (done) begin
         if (INT && ie_q) begin
            state_d = S_EXC;
            cause_d = CAUSE_INT;
         end else begin
            state_d = S_IF;
         end
      end

      if (timeout) begin
         MemRead  = 1'b0;
         MemWrite = 1'b0;
         state_d  = S_EXC;
         cause_d  = CAUSE_BUS;
      end

      // Hold every architectural write off while reset is asserted.
      if (!reset) begin
         IRWrite  = 1'b0;
         PCWrite  = 1'b0;
         RegWrite = 1'b0;
         EPCWrite = 1'b0;
         MemWrite = 1'b0;
      end
   end

   assign cause      = cause_q;
   assign IE         = ie_q;
   assign state      = STATE_W'(state_q);
   assign int_vector = INT_VECTOR;

endmodule

// File: tb/tb_mcpu_ctrl_v2.sv
// Directed bench for mcpu_ctrl_v2: load with waits, branches, illegal trap,
// ERET, interrupt at instruction boundary, jumps, memory stall and async reset.
module tb_mcpu_ctrl_v2;

   logic clk = 1'b0;
   logic reset;
   logic [5:0] opcode, funct;
   logic Zero, MIO_ready, INT;
   logic MemRead, MemWrite, IorD, IRWrite, RegWrite, ALUSrcA, ExtSigned, PCWrite, EPCWrite;
   logic [1:0] RegDst, MemtoReg, ALUSrcB, ALUOp, cause;
   logic [2:0] PCSrc;
   logic IE;
   logic [4:0] state;
   logic [31:0] int_vector;

   int n_assert = 0;
   int n_fail   = 0;

   mcpu_ctrl_v2 dut (
      .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .Zero(Zero),
      .MIO_ready(MIO_ready), .INT(INT), .MemRead(MemRead), .MemWrite(MemWrite),
      .IorD(IorD), .IRWrite(IRWrite), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
      .ExtSigned(ExtSigned), .PCWrite(PCWrite), .EPCWrite(EPCWrite), .RegDst(RegDst),
      .MemtoReg(MemtoReg), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSrc(PCSrc),
      .cause(cause), .IE(IE), .state(state), .int_vector(int_vector)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_assert++;
      assert (obs === exp_v) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Fetch with an immediate memory response and move into ID.
   task automatic fetch(input logic [5:0] op, input logic [5:0] fn);
      opcode = op; funct = fn; MIO_ready = 1'b1;
      #1;
      chk("if_state", 32'(state), 32'd0);
      chk("if_irwrite", 32'(IRWrite), 32'd1);
      tick();
      chk("id_state", 32'(state), 32'd1);
      chk("id_srcb", 32'(ALUSrcB), 32'd3);
   endtask

   int mr_reads, rw_pulses, irw_seen;

   initial begin
      reset = 1'b0; opcode = '0; funct = '0; Zero = 1'b0; MIO_ready = 1'b1; INT = 1'b0;
      #2;
      chk("rst_state", 32'(state), 32'd0);
      chk("rst_ie", 32'(IE), 32'd0);
      chk("rst_cause", 32'(cause), 32'd0);
      chk("rst_memread", 32'(MemRead), 32'd1);
      chk("rst_pcwrite", 32'(PCWrite), 32'd0);
      chk("rst_irwrite", 32'(IRWrite), 32'd0);
      chk("int_vector", int_vector, 32'h0000_0004);
      tick();
      chk("rst_hold_state", 32'(state), 32'd0);
      reset = 1'b1;

      // lw with three wait cycles in MR
      fetch(6'b100011, 6'd0);
      tick();
      chk("ma_state", 32'(state), 32'd2);
      chk("ma_srca", 32'(ALUSrcA), 32'd1);
      chk("ma_srcb", 32'(ALUSrcB), 32'd2);
      chk("ma_ext", 32'(ExtSigned), 32'd1);
      tick();
      mr_reads = 0; rw_pulses = 0;
      MIO_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (i == 3) MIO_ready = 1'b1;
         #1;
         chk("mr_state", 32'(state), 32'd3);
         chk("mr_iord", 32'(IorD), 32'd1);
         if (MemRead) mr_reads++;
         if (RegWrite) rw_pulses++;
         tick();
      end
      chk("mwb_state", 32'(state), 32'd4);
      chk("mwb_m2r", 32'(MemtoReg), 32'd1);
      chk("mwb_regdst", 32'(RegDst), 32'd0);
      if (RegWrite) rw_pulses++;
      tick();
      chk("lw_back_if", 32'(state), 32'd0);
      chk("lw_memread_cycles", 32'(mr_reads), 32'd4);
      chk("lw_regwrite_pulses", 32'(rw_pulses), 32'd1);

      // beq taken, then bne not taken, both with Zero=1
      Zero = 1'b1;
      fetch(6'b000100, 6'd0);
      tick();
      chk("beq_state", 32'(state), 32'd8);
      chk("beq_pcwrite", 32'(PCWrite), 32'd1);
      chk("beq_pcsrc", 32'(PCSrc), 32'd1);
      chk("beq_aluop", 32'(ALUOp), 32'd1);
      tick();
      chk("beq_back_if", 32'(state), 32'd0);
      fetch(6'b000101, 6'd0);
      tick();
      chk("bne_state", 32'(state), 32'd9);
      chk("bne_pcwrite", 32'(PCWrite), 32'd0);
      tick();
      chk("bne_back_if", 32'(state), 32'd0);
      Zero = 1'b0;

      // illegal opcode trap with IE=0
      fetch(6'b111111, 6'd0);
      chk("ill_id_regwrite", 32'(RegWrite), 32'd0);
      tick();
      chk("ill_exc_state", 32'(state), 32'd15);
      chk("ill_cause", 32'(cause), 32'd2);
      chk("ill_epcwrite", 32'(EPCWrite), 32'd1);
      chk("ill_regwrite", 32'(RegWrite), 32'd0);
      tick();
      chk("ill_back_if", 32'(state), 32'd0);
      chk("ill_cause_sticky", 32'(cause), 32'd2);

      // ERET sets IE; INT is not sampled in the ERET cycle
      fetch(6'b010000, 6'b011000);
      tick();
      INT = 1'b1;
      #1;
      chk("eret_state", 32'(state), 32'd16);
      chk("eret_pcsrc", 32'(PCSrc), 32'd4);
      chk("eret_pcwrite", 32'(PCWrite), 32'd1);
      tick();
      INT = 1'b0;
      chk("eret_back_if", 32'(state), 32'd0);
      chk("eret_ie", 32'(IE), 32'd1);

      // add with INT raised in RX: RWB completes, then EXC
      fetch(6'b000000, 6'b100000);
      tick();
      INT = 1'b1;
      #1;
      chk("rx_state", 32'(state), 32'd6);
      chk("rx_aluop", 32'(ALUOp), 32'd2);
      tick();
      chk("rwb_state", 32'(state), 32'd7);
      chk("rwb_regwrite", 32'(RegWrite), 32'd1);
      chk("rwb_regdst", 32'(RegDst), 32'd1);
      tick();
      chk("int_exc_state", 32'(state), 32'd15);
      chk("int_epcwrite", 32'(EPCWrite), 32'd1);
      chk("int_pcsrc", 32'(PCSrc), 32'd3);
      chk("int_cause", 32'(cause), 32'd1);
      INT = 1'b0;
      tick();
      chk("int_back_if", 32'(state), 32'd0);
      chk("int_ie_cleared", 32'(IE), 32'd0);
      fetch(6'b010000, 6'b011000);
      tick();
      chk("eret2_pcsrc", 32'(PCSrc), 32'd4);
      tick();
      chk("eret2_ie", 32'(IE), 32'd1);

      // jal / ori / addi / jr
      fetch(6'b000011, 6'd0);
      tick();
      chk("jal_state", 32'(state), 32'd11);
      chk("jal_regdst", 32'(RegDst), 32'd2);
      chk("jal_m2r", 32'(MemtoReg), 32'd2);
      chk("jal_pcsrc", 32'(PCSrc), 32'd2);
      tick();
      fetch(6'b001101, 6'd0);
      tick();
      chk("ori_state", 32'(state), 32'd12);
      chk("ori_ext", 32'(ExtSigned), 32'd0);
      chk("ori_aluop", 32'(ALUOp), 32'd3);
      tick();
      chk("ori_iwb_regwrite", 32'(RegWrite), 32'd1);
      tick();
      fetch(6'b001000, 6'd0);
      tick();
      chk("addi_ext", 32'(ExtSigned), 32'd1);
      tick(); tick();
      fetch(6'b000000, 6'b001000);
      tick();
      chk("jr_state", 32'(state), 32'd14);
      chk("jr_pcsrc", 32'(PCSrc), 32'd5);
      tick();
      chk("jr_back_if", 32'(state), 32'd0);

      // fetch stall with MIO_ready held low
      MIO_ready = 1'b0;
      irw_seen = 0;
`ifdef MCTRL_BUS_TIMEOUT_EN
      for (int i = 0; i < 16; i++) begin
         #1;
         if (IRWrite) irw_seen++;
         tick();
      end
      chk("to_exc_state", 32'(state), 32'd15);
      chk("to_cause", 32'(cause), 32'd3);
      tick();
`else
      for (int i = 0; i < 20; i++) begin
         #1;
         if (IRWrite) irw_seen++;
         tick();
      end
      chk("stall_state", 32'(state), 32'd0);
      chk("stall_cause", 32'(cause), 32'd1);
`endif
      chk("stall_irwrite", 32'(irw_seen), 32'd0);

      // sw stalled in MW, then asynchronous reset mid-cycle
      fetch(6'b101011, 6'd0);
      tick();
      tick();
      MIO_ready = 1'b0;
      #1;
      chk("mw_state", 32'(state), 32'd5);
      chk("mw_memwrite", 32'(MemWrite), 32'd1);
      #1;
      reset = 1'b0;
      #1;
      chk("arst_state", 32'(state), 32'd0);
      chk("arst_memwrite", 32'(MemWrite), 32'd0);
      chk("arst_pcwrite", 32'(PCWrite), 32'd0);
      tick();
      reset = 1'b1;
      #1;
      chk("arst_ie", 32'(IE), 32'd0);
      chk("arst_cause", 32'(cause), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/mcpu_ctrl_v2.md
Name: mcpu_ctrl_v2

Overview:
- Second-generation multi-cycle MIPS control FSM for the MCPU datapath.
- Adds a real memory wait-state handshake on MIO_ready, precise external interrupts and exceptions with EPC capture and ERET, and an illegal-opcode trap.
- Vector address and exception behaviour are parametrised.
- Drives every datapath strobe and mux select.

Parameters:
- STATE_W, 5, width of the state debug output
- INT_VECTOR, 32'h0000_0004, PC loaded on exception entry; exported to the datapath mux
- IE_RST, 1'b0, interrupt-enable value after reset
- BUS_TIMEOUT, 16, wait cycles before a bus error (optional feature only)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- opcode  in  6  IR[31:26]
- funct  in  6  IR[5:0]
- Zero  in  1  ALU zero flag
- MIO_ready  in  1  memory transfer complete this cycle
- INT  in  1  level-sensitive external interrupt request
- MemRead, MemWrite, IorD, IRWrite, RegWrite, ALUSrcA, ExtSigned, PCWrite, EPCWrite  out  1 each  datapath strobes/selects
- RegDst  out  2  0=rt, 1=rd, 2=r31
- MemtoReg  out  2  0=ALUOut, 1=MDR, 2=PC
- ALUSrcB  out  2  0=B, 1=4, 2=imm, 3=imm<<2
- ALUOp  out  2  0=add, 1=sub, 2=funct, 3=opcode-decoded
- PCSrc  out  3  0=ALU result, 1=ALUOut, 2=jump, 3=INT_VECTOR, 4=EPC, 5=rs
- cause  out  2  0=none, 1=INT, 2=illegal, 3=bus timeout; sticky until the next exception
- IE  out  1  interrupt enable
- state  out  STATE_W  current state

Behaviour:
- States: IF=0, ID=1, MA=2, MR=3, MWB=4, MW=5, RX=6, RWB=7, BEQ=8, BNE=9, J=10, JAL=11, IX=12, IWB=13, JR=14, EXC=15, ERET=16. Unused codes return to IF.
- Reset, asynchronous while reset=0:
  - state=IF, IE=IE_RST, cause=0.
  - All strobes are combinational from state and therefore 0 except IF's MemRead. No register write or PC write occurs during reset.
- IF:
  - MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=1, PCSrc=0.
  - IRWrite and PCWrite assert only in the cycle MIO_ready=1; the FSM stays in IF until then.
- ID: ALUSrcB=3 (computes the branch target); dispatch on opcode/funct:
  - lw/sw -> MA
  - R-type -> RX; funct 001000 (jr) -> JR
  - beq -> BEQ; bne -> BNE
  - j -> J; jal -> JAL
  - addi/andi/ori/slti/lui -> IX
  - opcode 010000 with funct 011000 -> ERET
  - anything else -> EXC with cause=2
- MA: ALUSrcA=1, ALUSrcB=2, ExtSigned=1. Next state MR (lw) or MW (sw).
- MR/MW: IorD=1; MemRead or MemWrite held asserted until MIO_ready=1, then MWB or IF respectively.
- MWB: RegWrite=1, RegDst=0, MemtoReg=1.
- RX then RWB: ALUOp=2; RWB has RegDst=1, RegWrite=1.
- IX then IWB:
  - ALUOp=3; ExtSigned=0 for andi/ori, 1 otherwise.
  - IWB has RegDst=0, RegWrite=1.
- BEQ/BNE: ALUOp=1, PCSrc=1. PCWrite=Zero for BEQ, !Zero for BNE. Next state IF.
- J: PCSrc=2, PCWrite=1.
- JAL: RegDst=2, MemtoReg=2, RegWrite=1, PCSrc=2, PCWrite=1. The register write uses PC before the update.
- JR: PCSrc=5, PCWrite=1.
- Interrupt sampling: in the last state of any instruction (the cycle whose next state would be IF), if INT&&IE then next state is EXC with cause=1.
- EXC: EPCWrite=1, PCSrc=3, PCWrite=1, IE<=0; next state IF.
- EPC semantics: EPC takes the already-incremented PC (address of the next instruction); for an illegal opcode, PC+4 of the faulting instruction.
- ERET: PCSrc=4, PCWrite=1, IE<=1; interrupts are not sampled in the ERET cycle.
- INT arriving mid-instruction or during memory waits has no effect until the instruction boundary.
- An exception while IE=0 (illegal opcode) is still taken.

Optional Feature:
- MCTRL_BUS_TIMEOUT_EN:
  - Defined: a counter runs in IF/MR/MW while MIO_ready=0. After BUS_TIMEOUT consecutive wait cycles the FSM abandons the access (no IRWrite, PCWrite, or register write), drops MemRead/MemWrite, and enters EXC with cause=3. The counter clears on MIO_ready or on a state change.
  - Undefined: the FSM waits indefinitely and cause never takes value 3.

Decomposition:
- Package mcpu_pkg: state encodings, opcode/funct constants, PCSrc/RegDst/MemtoReg/ALUSrcB/ALUOp/cause encodings, INT_VECTOR default.
- One sub-module, mcpu_ctrl_decode: combinational opcode/funct -> dispatch state and illegal flag, used by ID.

Test Plan:
- lw with 3 wait cycles in MR: states IF,ID,MA,MR×4,MWB; RegWrite pulses once; MemRead high 4 cycles.
- beq with Zero=1, then bne with Zero=1: PCWrite=1 in BEQ; PCWrite=0 in BNE; both return to IF.
- INT=1, IE=1 asserted during RX of an add: RWB completes, then EXC (EPCWrite=1, PCSrc=3, cause=1, IE->0), then IF. ERET restores IE=1 with PCSrc=4.
- Opcode 6'b111111 at ID: EXC with cause=2 even when IE=0; RegWrite never asserted.
- reset driven low mid-MW: state=0 and MemWrite=0 immediately without a clock; IE=IE_RST after release.
- With MCTRL_BUS_TIMEOUT_EN and MIO_ready held 0 in IF: after 16 cycles EXC with cause=3; IRWrite never asserted.
